// File: rtl/muxed_accumulator.sv
// Two-stage accumulator: stage 1 captures the selected channel and the request,
// stage 2 applies load/add/sub/clear with optional saturation and a sticky overflow.
module muxed_accumulator #(
  parameter int WIDTH     = 3,
  parameter int CHANNELS  = 8,
  parameter int ACC_WIDTH = WIDTH + 1,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic [1:0]                op,
  input  logic                      sat_en,
  input  logic                      in_valid,
  output logic [ACC_WIDTH-1:0]      acc,
  output logic                      out_valid,
  output logic                      overflow,
  output logic                      sel_err
);

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  logic [WIDTH-1:0] chan [CHANNELS];

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign chan[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic                 s1_valid_q, s1_valid_d;
  logic [ACC_WIDTH-1:0] s1_operand_q, s1_operand_d;
  op_e                  s1_op_q, s1_op_d;
  logic                 s1_sat_q, s1_sat_d;
  logic                 s1_err_q, s1_err_d;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 out_valid_q, out_valid_d;
  logic                 overflow_q, overflow_d;
  logic                 sel_err_q, sel_err_d;

  // Out-of-range selects fall through the search with operand 0 and the error bit set.
  always_comb begin
    s1_valid_d   = in_valid;
    s1_operand_d = s1_operand_q;
    s1_op_d      = s1_op_q;
    s1_sat_d     = s1_sat_q;
    s1_err_d     = s1_err_q;
    if (in_valid) begin
      s1_operand_d = '0;
      s1_err_d     = 1'b1;
      s1_op_d      = op_e'(op);
      s1_sat_d     = sat_en;
      for (int k = 0; k < CHANNELS; k++) begin
        if (sel == SEL_W'(k)) begin
          s1_operand_d = ACC_WIDTH'(chan[k]);
          s1_err_d     = 1'b0;
        end
      end
    end
  end

  // One extra bit catches the ADD carry-out and the SUB borrow.
  logic [ACC_WIDTH:0] sum;
  logic [ACC_WIDTH:0] diff;
  assign sum  = {1'b0, acc_q} + {1'b0, s1_operand_q};
  assign diff = {1'b0, acc_q} - {1'b0, s1_operand_q};

  always_comb begin
    acc_d       = acc_q;
    overflow_d  = overflow_q;
    out_valid_d = s1_valid_q;
    sel_err_d   = s1_valid_q & s1_err_q;
    if (s1_valid_q) begin
      case (s1_op_q)
        OP_LOAD: acc_d = s1_operand_q;
        OP_ADD: begin
          acc_d = sum[ACC_WIDTH-1:0];
          if (sum[ACC_WIDTH]) begin
            overflow_d = 1'b1;
            if (s1_sat_q) acc_d = '1;
          end
        end
        OP_SUB: begin
          acc_d = diff[ACC_WIDTH-1:0];
          if (diff[ACC_WIDTH]) begin
            overflow_d = 1'b1;
            if (s1_sat_q) acc_d = '0;
          end
        end
        OP_CLEAR: begin
          acc_d      = '0;
          overflow_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_operand_q <= '0;
      s1_op_q      <= OP_LOAD;
      s1_sat_q     <= 1'b0;
      s1_err_q     <= 1'b0;
      acc_q        <= '0;
      out_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      sel_err_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_operand_q <= s1_operand_d;
      s1_op_q      <= s1_op_d;
      s1_sat_q     <= s1_sat_d;
      s1_err_q     <= s1_err_d;
      acc_q        <= acc_d;
      out_valid_q  <= out_valid_d;
      overflow_q   <= overflow_d;
      sel_err_q    <= sel_err_d;
    end
  end

  assign acc       = acc_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_muxed_accumulator.sv
// Bench for muxed_accumulator: directed vector table, a CHANNELS=6 select-error
// sequence, and randomized traffic against an arithmetic reference model.
module tb_muxed_accumulator;

  localparam int W   = 3;
  localparam int CH  = 8;
  localparam int AW  = 4;
  localparam int MAXV = (1 << AW) - 1;
  localparam int CH6 = 6;

  localparam int LOAD  = 0;
  localparam int ADD   = 1;
  localparam int SUB   = 2;
  localparam int CLEAR = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH*W-1:0] in_data;
  logic [2:0]      sel;
  logic [1:0]      op;
  logic            sat_en;
  logic            in_valid;
  logic [AW-1:0]   acc;
  logic            out_valid, overflow, sel_err;

  logic             rst_n6;
  logic [CH6*W-1:0] in_data6;
  logic [2:0]       sel6;
  logic [1:0]       op6;
  logic             sat_en6, in_valid6;
  logic [AW-1:0]    acc6;
  logic             out_valid6, overflow6, sel_err6;

  always #5 clk = ~clk;

  muxed_accumulator #(.WIDTH(W), .CHANNELS(CH), .ACC_WIDTH(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .op(op),
    .sat_en(sat_en), .in_valid(in_valid), .acc(acc), .out_valid(out_valid),
    .overflow(overflow), .sel_err(sel_err)
  );

  muxed_accumulator #(.WIDTH(W), .CHANNELS(CH6), .ACC_WIDTH(AW)) u_dut6 (
    .clk(clk), .rst_n(rst_n6), .in_data(in_data6), .sel(sel6), .op(op6),
    .sat_en(sat_en6), .in_valid(in_valid6), .acc(acc6), .out_valid(out_valid6),
    .overflow(overflow6), .sel_err(sel_err6)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit rst_n;
    bit in_valid;
    int sel;
    int op;
    bit sat;
    int e_acc;
    bit e_ov;
    bit e_ovf;
    bit e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit v, input int s, input int o, input bit sa,
                     input int ea, input bit eo, input bit ef, input bit ee);
    vec_t t;
    t = '{rst_n: r, in_valid: v, sel: s, op: o, sat: sa,
          e_acc: ea, e_ov: eo, e_ovf: ef, e_err: ee};
    vecs.push_back(t);
  endtask

  // Reference model state: committed accumulator and the one request in flight.
  int  m_acc, m_val;
  bit  m_ovf, m_ov, m_err;
  bit  p_v, p_err, p_sat;
  int  p_val, p_op;

  task automatic model_edge(input bit r, input bit v, input int s, input int o,
                            input bit sa, input logic [CH*W-1:0] data);
    int res;
    if (!r) begin
      m_acc = 0; m_ovf = 0; m_ov = 0; m_err = 0; p_v = 0;
      return;
    end
    m_ov = 0;
    m_err = 0;
    if (p_v) begin
      m_ov = 1;
      m_err = p_err;
      case (p_op)
        LOAD: m_acc = p_val;
        ADD: begin
          res = m_acc + p_val;
          if (res > MAXV) begin
            m_ovf = 1;
            res = p_sat ? MAXV : res - (MAXV + 1);
          end
          m_acc = res;
        end
        SUB: begin
          res = m_acc - p_val;
          if (res < 0) begin
            m_ovf = 1;
            res = p_sat ? 0 : res + (MAXV + 1);
          end
          m_acc = res;
        end
        default: begin
          m_acc = 0;
          m_ovf = 0;
        end
      endcase
    end
    p_v = v;
    if (v) begin
      p_err = (s >= CH);
      p_val = p_err ? 0 : int'((data >> (s * W)) & ((1 << W) - 1));
      p_op  = o;
      p_sat = sa;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; sel = '0; op = '0; sat_en = 1'b0;
    rst_n6 = 1'b0; in_valid6 = 1'b0; sel6 = '0; op6 = '0; sat_en6 = 1'b0;
    for (int k = 0; k < CH; k++) in_data[k*W +: W] = W'(k);
    for (int k = 0; k < CH6; k++) in_data6[k*W +: W] = W'(k);

    //    rst v  sel op     sat  acc ov ovf err  (outputs after the edge)
    add(0, 1, 5, LOAD,  0,   0, 0, 0, 0);   // reset held with a request present
    add(0, 1, 5, LOAD,  0,   0, 0, 0, 0);
    add(1, 0, 0, LOAD,  0,   0, 0, 0, 0);   // no pulse after release
    add(1, 0, 0, LOAD,  0,   0, 0, 0, 0);
    add(1, 1, 5, LOAD,  0,   0, 0, 0, 0);   // back-to-back pipeline
    add(1, 1, 7, ADD,   0,   5, 1, 0, 0);
    add(1, 0, 0, LOAD,  0,  12, 1, 0, 0);
    add(1, 0, 0, LOAD,  0,  12, 0, 0, 0);
    add(1, 1, 7, LOAD,  0,  12, 0, 0, 0);   // wrap
    add(1, 1, 7, ADD,   0,   7, 1, 0, 0);
    add(1, 1, 7, ADD,   0,  14, 1, 0, 0);
    add(1, 1, 2, LOAD,  0,   5, 1, 1, 0);
    add(1, 1, 0, CLEAR, 0,   2, 1, 1, 0);
    add(1, 0, 0, LOAD,  0,   0, 1, 0, 0);
    add(1, 0, 0, LOAD,  0,   0, 0, 0, 0);
    add(1, 1, 7, LOAD,  1,   0, 0, 0, 0);   // saturate
    add(1, 1, 7, ADD,   1,   7, 1, 0, 0);
    add(1, 1, 7, ADD,   1,  14, 1, 0, 0);
    add(1, 1, 3, LOAD,  1,  15, 1, 1, 0);
    add(1, 1, 6, SUB,   1,   3, 1, 1, 0);
    add(1, 0, 0, LOAD,  0,   0, 1, 1, 0);
    add(1, 1, 3, ADD,   0,   0, 0, 1, 0);   // request then reset mid-flight
    add(0, 0, 0, LOAD,  0,   0, 0, 0, 0);
    add(1, 0, 0, LOAD,  0,   0, 0, 0, 0);
    add(1, 1, 2, LOAD,  0,   0, 0, 0, 0);   // wrapping subtract
    add(1, 1, 5, SUB,   0,   2, 1, 0, 0);
    add(1, 0, 0, LOAD,  0,  13, 1, 1, 0);
    add(1, 0, 0, LOAD,  0,  13, 0, 1, 0);

    foreach (vecs[i]) begin
      rst_n    = vecs[i].rst_n;
      in_valid = vecs[i].in_valid;
      sel      = 3'(vecs[i].sel);
      op       = 2'(vecs[i].op);
      sat_en   = vecs[i].sat;
      @(posedge clk);
      #1;
      $display("vec %0d: rst_n=%0d v=%0d sel=%0d op=%0d sat=%0d -> acc=%0d ov=%0d ovf=%0d err=%0d",
               i, rst_n, in_valid, sel, op, sat_en, acc, out_valid, overflow, sel_err);
      chk($sformatf("vec%0d_acc", i), 32'(acc), vecs[i].e_acc);
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), int'(vecs[i].e_ov));
      chk($sformatf("vec%0d_overflow", i), 32'(overflow), int'(vecs[i].e_ovf));
      chk($sformatf("vec%0d_sel_err", i), 32'(sel_err), int'(vecs[i].e_err));
    end
    in_valid = 1'b0;

    // CHANNELS=6: sel=7 is out of range, operand 0, sel_err on its own result only.
    repeat (2) @(posedge clk);
    #1;
    rst_n6 = 1'b1; in_valid6 = 1'b1; sel6 = 3'd4; op6 = 2'(LOAD);
    @(posedge clk); #1;
    chk("ch6_first_out_valid", 32'(out_valid6), 0);
    sel6 = 3'd7; op6 = 2'(ADD);
    @(posedge clk); #1;
    $display("ch6 LOAD 4: acc=%0d ov=%0d err=%0d", acc6, out_valid6, sel_err6);
    chk("ch6_load_acc", 32'(acc6), 4);
    chk("ch6_load_ov", 32'(out_valid6), 1);
    chk("ch6_load_err", 32'(sel_err6), 0);
    in_valid6 = 1'b0;
    @(posedge clk); #1;
    $display("ch6 ADD sel7: acc=%0d ov=%0d err=%0d", acc6, out_valid6, sel_err6);
    chk("ch6_bad_acc", 32'(acc6), 4);
    chk("ch6_bad_ov", 32'(out_valid6), 1);
    chk("ch6_bad_err", 32'(sel_err6), 1);
    @(posedge clk); #1;
    chk("ch6_idle_ov", 32'(out_valid6), 0);
    chk("ch6_idle_err", 32'(sel_err6), 0);
    chk("ch6_idle_acc", 32'(acc6), 4);

    // Randomized traffic; the first cycle is a reset to align the model.
    rst_n = 1'b0; in_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      model_edge(rst_n, in_valid, int'(sel), int'(op), sat_en, in_data);
      #1;
      if (in_valid && rst_n)
        $display("rnd %0d: sel=%0d op=%0d sat=%0d data=%0d -> acc=%0d ovf=%0d",
                 n, sel, op, sat_en, (in_data >> (sel * W)) & 3'h7, acc, overflow);
      chk("rnd_acc", 32'(acc), m_acc);
      chk("rnd_out_valid", 32'(out_valid), int'(m_ov));
      chk("rnd_overflow", 32'(overflow), int'(m_ovf));
      chk("rnd_sel_err", 32'(sel_err), int'(m_err));
      rst_n    = ($urandom_range(39) != 0);
      in_valid = ($urandom_range(3) != 0);
      sel      = 3'($urandom_range(CH - 1));
      op       = 2'($urandom_range(3));
      sat_en   = 1'($urandom_range(1));
      in_data  = (CH*W)'($urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muxed_accumulator.md
# muxed_accumulator

Parametrised successor to the single-input summer. It selects one of `CHANNELS` input words through an internal multiplexer and applies a load, add, subtract or clear operation to a registered accumulator. Arithmetic can wrap or saturate, and overflow is reported. The block sits between the input-select mux and downstream display/compare logic, and is pipelined for two-cycle latency with a valid strobe.

## Interface
- `WIDTH`, 3: bit width of each input channel.
- `CHANNELS`, 8: number of input channels (≥2).
- `ACC_WIDTH`, WIDTH+1: accumulator width (≥WIDTH).
- `SEL_W`, $clog2(CHANNELS): select width (derived, not overridden).
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `in_data`  in  CHANNELS*WIDTH: packed channels; channel k is `in_data[k*WIDTH +: WIDTH]`.
- `sel`  in  SEL_W: channel select.
- `op`  in  2: 00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
- `sat_en`  in  1: 1 saturates, 0 wraps.
- `in_valid`  in  1: request strobe; `sel`/`op`/`sat_en`/selected data sampled when high.
- `acc`  out  ACC_WIDTH: accumulator value.
- `out_valid`  out  1: one-cycle pulse, `acc` just updated by a request.
- `overflow`  out  1: sticky flag; wrap or clamp occurred since last CLEAR/reset.
- `sel_err`  out  1: pulse aligned with `out_valid`; request used `sel ≥ CHANNELS`.

## Operation
- Stage 1 (capture):
  - On a rising edge with `in_valid=1`, register operand = selected channel, zero-extended to ACC_WIDTH, together with `op`, `sat_en`, a range-error bit and s1_valid.
  - With `sel ≥ CHANNELS`, the operand is 0 and the error bit is set; `op` still executes.
  - With `in_valid=0`, s1_valid clears; operand/op registers may hold stale values.
- Stage 2 (execute), on an edge with s1_valid=1:
  - LOAD: `acc` ← operand.
  - ADD: `acc` ← `acc` + operand, computed at ACC_WIDTH+1 bits.
  - SUB: `acc` ← `acc` − operand, unsigned.
  - CLEAR: `acc` ← 0 and `overflow` ← 0; the operand is ignored.
- Arithmetic is unsigned.
  - ADD carry-out with `sat_en=0`: keep the low ACC_WIDTH bits.
  - ADD carry-out with `sat_en=1`: `acc` ← 2^ACC_WIDTH−1.
  - SUB borrow with `sat_en=0`: wrap modulo 2^ACC_WIDTH.
  - SUB borrow with `sat_en=1`: `acc` ← 0.
  - Any carry or borrow sets `overflow`, whatever `sat_en` is.
- `overflow` clears only on CLEAR or reset. LOAD does not clear it.
- Back-to-back requests (in_valid every cycle) are fully supported:
  - Stage 2 always operates on its own current `acc`, so there is no hazard or stall.
  - Throughput is one request per cycle.
- There is no backpressure; the block is always ready.

## Timing
- Request sampled at edge N: `acc` updates and `out_valid`/`sel_err` rise at edge N+1, and are visible for the cycle after N+1.
- Latency is 2 edges from the first edge with `in_valid` high.
- `out_valid` and `sel_err` stay high exactly one cycle per request.
- Reset: any edge with `rst_n=0` sets `acc=0`, `out_valid=0`, `overflow=0` and `sel_err=0`, and clears s1_valid.
  - In-flight requests are discarded and produce no `out_valid`.
  - Requests with `in_valid=1` during reset are ignored.
- The first request is accepted at the first edge with `rst_n=1`.
- Between requests, `acc` holds its value.

## Test plan
All scenarios use the defaults WIDTH=3, CHANNELS=8, ACC_WIDTH=4, with channel k driven to value k unless stated.
- Reset: hold `rst_n=0` for 2 edges with `in_valid=1`, op=LOAD, sel=5 -> `acc=0`, `out_valid=0`, `overflow=0` throughout; no pulse after release.
- Pipelining: LOAD sel=5 then ADD sel=7 on consecutive cycles -> `acc`=5 with `out_valid` 2 edges after the first request, then `acc`=12 the next cycle; `out_valid` high 2 consecutive cycles.
- Wrap: LOAD 7, ADD 7, ADD 7 with `sat_en=0` -> `acc`=7, 14, 5; `overflow` rises with the third result and stays 1 through a later LOAD 2 (`acc`=2); CLEAR -> `acc`=0, `overflow`=0.
- Saturate: LOAD 7, ADD 7, ADD 7 with `sat_en=1` -> 7, 14, 15, `overflow`=1; then LOAD 3, SUB sel=6 -> `acc`=0.
- Select error: rebuild with CHANNELS=6 (SEL_W=3); LOAD 4 then ADD sel=7 -> `acc` stays 4; `sel_err` pulses with the second `out_valid` only.
- Reset mid-operation: ADD sel=3 with `in_valid` at edge N, `rst_n=0` at edge N+1 -> no `out_valid` pulse; `acc=0` after N+1.
